wb_stage: RTL and testbench



---
 rtl/wb_stage_if.sv | 40 ++++
 rtl/wb_stage.sv | 93 +++++++++
 tb/tb_wb_stage.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundle between the memory stage and the writeback stage.
//   Memory-stage side (master) drives: freeze, flush, valid_in, WB_EN_in,
//     MEM_R_EN_in, dest_in, ALU_result_in, Mem_read_value.
//   Writeback side (slave) drives: WB_EN, WB_Dest, WB_Value, valid_out.
//     These outputs also feed the register-file write port and the
//     forwarding unit.
// Parameters DATA_W / REG_ADDR_W must match those of the wb_stage instance.
// -----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) ();
  logic                  freeze;
  logic                  flush;
  logic                  valid_in;
  logic                  WB_EN_in;
  logic                  MEM_R_EN_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0]     ALU_result_in;
  logic [DATA_W-1:0]     Mem_read_value;

  logic                  WB_EN;
  logic [REG_ADDR_W-1:0] WB_Dest;
  logic [DATA_W-1:0]     WB_Value;
  logic                  valid_out;

  modport master (
    output freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, dest_in,
           ALU_result_in, Mem_read_value,
    input  WB_EN, WB_Dest, WB_Value, valid_out
  );

  modport slave (
    input  freeze, flush, valid_in, WB_EN_in, MEM_R_EN_in, dest_in,
           ALU_result_in, Mem_read_value,
    output WB_EN, WB_Dest, WB_Value, valid_out
  );
endinterface

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MIPS writeback stage: holds the MEM/WB pipeline register and drives the
// register-file write port (shared with the forwarding unit).
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus (slave)   memory-stage inputs and writeback outputs, see wb_stage_if
//   retire_count  32-bit retired-instruction count (only with WB_RETIRE_CNT_EN)
//
// Optional feature: define WB_RETIRE_CNT_EN to build the retire counter and
// its output port. Without it the counter and port do not exist.
//
// Register update priority per edge: reset > flush > freeze > load.
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  logic                  r_valid;
  logic                  r_wb_en;
  logic                  r_mem_r_en;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0]     r_alu_result;
  logic [DATA_W-1:0]     r_mem_data;

  logic                  w_load;

  // A load happens only on edges that neither flush nor freeze.
  assign w_load = !bus.flush && !bus.freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
    end else if (bus.flush) begin
      // Bubble; data fields cleared so the outputs are deterministic.
      r_valid      <= 1'b0;
      r_wb_en      <= 1'b0;
      r_mem_r_en   <= 1'b0;
      r_dest       <= '0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
    end else if (w_load) begin
      r_valid      <= bus.valid_in;
      // A non-valid slot must never write, whatever WB_EN_in says.
      r_wb_en      <= bus.WB_EN_in & bus.valid_in;
      r_mem_r_en   <= bus.MEM_R_EN_in;
      r_dest       <= bus.dest_in;
      r_alu_result <= bus.ALU_result_in;
      r_mem_data   <= bus.Mem_read_value;
    end
  end

  // Loads take the memory value, everything else the ALU result.
  assign bus.WB_Value  = r_mem_r_en ? r_mem_data : r_alu_result;
  assign bus.WB_Dest   = r_dest;
  // $0 is hard-wired zero, so writes to it are dropped here once for both
  // the register file and the forwarding unit.
  assign bus.WB_EN     = r_wb_en & r_valid & (r_dest != '0);
  assign bus.valid_out = r_valid;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Counts every valid instruction that enters the register, including
  // ones that do not write the register file. Wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_load && bus.valid_in) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_count = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage. A small model holds what the writeback
// slot should present (valid, effective write enable, destination, selected
// value, retire count) and is updated from the stage's documented rules.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected architectural view of the writeback slot.
  logic        m_valid;
  logic        m_wb;
  logic [4:0]  m_dest;
  logic [31:0] m_value;
  logic [31:0] m_cnt;

  logic [38:0] got;
  logic [38:0] exp;

  task automatic model_reset();
    m_valid = 1'b0;
    m_wb    = 1'b0;
    m_dest  = 5'd0;
    m_value = 32'd0;
    m_cnt   = 32'd0;
  endtask

  task automatic drive(input logic fz, input logic fl, input logic v,
                       input logic we, input logic mr, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem);
    bus.freeze         = fz;
    bus.flush          = fl;
    bus.valid_in       = v;
    bus.WB_EN_in       = we;
    bus.MEM_R_EN_in    = mr;
    bus.dest_in        = d;
    bus.ALU_result_in  = alu;
    bus.Mem_read_value = mem;
  endtask

  // Drive one cycle of inputs, take the clock edge, update the model,
  // and leave time 1 unit after the edge for sampling.
  task automatic step(input logic fz, input logic fl, input logic v,
                      input logic we, input logic mr, input logic [4:0] d,
                      input logic [31:0] alu, input logic [31:0] mem);
    drive(fz, fl, v, we, mr, d, alu, mem);
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      m_wb    = 1'b0;
      m_dest  = 5'd0;
      m_value = 32'd0;
    end else if (!fz) begin
      m_valid = v;
      m_wb    = v && we && (d != 5'd0);
      m_dest  = d;
      m_value = mr ? mem : alu;
      if (v) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic sample();
    got = {bus.valid_out, bus.WB_EN, bus.WB_Dest, bus.WB_Value};
    exp = {m_valid, m_wb, m_dest, m_value};
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    n_checks++;
    if (got !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", got, 39'd0);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h55, 32'hAAAA_0001);
    // Async reset between edges with every input nonzero.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    sample();
    n_checks++;
    if (got !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %h required %h", got, 39'd0);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retire_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %h required 0", retire_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h9999);
    n_checks++;
    if ({bus.WB_EN, bus.WB_Dest, bus.WB_Value} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++;
      $display("FAIL reset_first_load: got %b/%0d/%h required 1/5/00001234",
               bus.WB_EN, bus.WB_Dest, bus.WB_Value);
    end
  endtask

  task automatic test_load_select();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h40, 32'hDEAD_BEEF);
    n_checks++;
    if (bus.WB_Value !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_sel_mem: got %h required deadbeef", bus.WB_Value);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h40, 32'hDEAD_BEEF);
    n_checks++;
    if (bus.WB_Value !== 32'h40) begin
      n_fail++;
      $display("FAIL load_sel_alu: got %h required 00000040", bus.WB_Value);
    end
    // Non-valid slot with WB_EN_in=1 never writes.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h41, 32'h0);
    n_checks++;
    if ({bus.valid_out, bus.WB_EN} !== 2'b00) begin
      n_fail++;
      $display("FAIL invalid_no_write: got valid=%b en=%b required 0/0",
               bus.valid_out, bus.WB_EN);
    end
  endtask

  task automatic test_zero_dest();
    logic [31:0] c0;
    c0 = m_cnt;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0);
    n_checks++;
    if ({bus.valid_out, bus.WB_EN} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_dest: got valid=%b en=%b required 1/0",
               bus.valid_out, bus.WB_EN);
    end
`ifdef WB_RETIRE_CNT_EN
    n_checks++;
    if (retire_count !== c0 + 32'd1) begin
      n_fail++;
      $display("FAIL zero_dest_count: got %h required %h", retire_count, c0 + 32'd1);
    end
`endif
  endtask

  task automatic test_freeze();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h11, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h22, 32'h0);
      n_checks++;
      if ({bus.WB_EN, bus.WB_Dest, bus.WB_Value} !== {1'b1, 5'd7, 32'h11}) begin
        n_fail++;
        $display("FAIL freeze_hold%0d: got %b/%0d/%h required 1/7/00000011",
                 i, bus.WB_EN, bus.WB_Dest, bus.WB_Value);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h22, 32'h0);
    n_checks++;
    if ({bus.WB_EN, bus.WB_Dest, bus.WB_Value} !== {1'b1, 5'd9, 32'h22}) begin
      n_fail++;
      $display("FAIL freeze_release: got %b/%0d/%h required 1/9/00000022",
               bus.WB_EN, bus.WB_Dest, bus.WB_Value);
    end
  endtask

  task automatic test_flush_priority();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h1, 32'hCAFE);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 32'h2, 32'hBEEF);
    n_checks++;
    if ({bus.valid_out, bus.WB_EN, bus.WB_Value} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_priority: got %b/%b/%h required 0/0/00000000",
               bus.valid_out, bus.WB_EN, bus.WB_Value);
    end
  endtask

  task automatic test_random();
    logic fz, fl, v, we, mr;
    logic [4:0] d;
    for (int i = 0; i < 300; i++) begin
      fz = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 4) != 0);
      we = $urandom_range(0, 1) == 1;
      mr = $urandom_range(0, 1) == 1;
      d  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(fz, fl, v, we, mr, d, $urandom, $urandom);
      sample();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random%0d: got v/en/dest/val %b/%b/%0d/%h required %b/%b/%0d/%h",
                 i, got[38], got[37], got[36:32], got[31:0],
                 exp[38], exp[37], exp[36:32], exp[31:0]);
      end
`ifdef WB_RETIRE_CNT_EN
      n_checks++;
      if (retire_count !== m_cnt) begin
        n_fail++;
        $display("FAIL random_count%0d: got %h required %h", i, retire_count, m_cnt);
      end
`endif
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_counter();
    @(negedge clk);
    dut.r_retire_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h0, 32'h0);
    n_checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL count_max: got %h required ffffffff", retire_count);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0);
    n_checks++;
    if (retire_count !== 32'h0) begin
      n_fail++;
      $display("FAIL count_wrap: got %h required 00000000", retire_count);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0);
    n_checks++;
    if (retire_count !== 32'h0) begin
      n_fail++;
      $display("FAIL count_hold: got %h required 00000000", retire_count);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_load_select();
    test_zero_dest();
    test_freeze();
    test_flush_priority();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
